// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a pipelined ALU: queues {a, b, sel} commands,
// issues them one at a time, waits out the ALU latency and returns results in order.
module alu_cmd_sequencer #(
  parameter int DATA_W     = 4,
  parameter int SEL_W      = 4,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [OUT_W-1:0]  alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_carry,
  output logic [SEL_W-1:0]  res_sel,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int CMD_W = 2 * DATA_W + SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [LAT_W-1:0] lat_cnt;

  logic full, empty, push, pop;
  logic capture, lat_dec, res_done;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Ready comes from registered occupancy only, so a pop never frees a slot
  // in the same cycle and res_ready has no path to cmd_ready.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // NOTE: the storage array has no reset; every entry is written before it can
  // be read, and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    lat_dec    = 1'b0;
    res_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else begin
          lat_dec = 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ALU operands stay on the last issued command until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      lat_cnt <= '0;
    end else if (pop) begin
      {alu_a, alu_b, alu_sel} <= mem[rd_ptr];
      lat_cnt                 <= LAT_W'(ALU_LAT);
    end else if (lat_dec) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Result fields keep their last value after the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_sel   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_carry <= alu_carry;
      res_sel   <= alu_sel;
    end else if (res_done) begin
      res_valid <= 1'b0;
    end
  end

  assign busy = !((state == IDLE) && empty);

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(FIFO_DEPTH));

  a_pop_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> !empty);

  a_res_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data)
                                   && $stable(res_carry) && $stable(res_sel)));
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer: a behavioural ALU drives the DUT and a
// queue-based scoreboard checks every returned result against push order.
module tb_alu_cmd_sequencer;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0, cmd_sel = '0;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_out = '0;
  logic       alu_carry = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry;
  logic [3:0] res_sel;
  logic       busy;

  int   n_checks = 0;
  int   n_bad    = 0;
  int   n_res    = 0;
  int   n_push   = 0;
  cmd_t exp_q[$];

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_sel   (res_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Golden ALU: returns {carry, result}; carry is the carry out of a + b.
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] sel);
    logic [7:0] r;
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (sel)
      4'd0:    r = {3'b0, s};
      4'd1:    r = {4'b0, a} - {4'b0, b};
      4'd2:    r = {4'b0, a} * {4'b0, b};
      4'd3:    r = (b == 4'd0) ? 8'h00 : {4'b0, a / b};
      4'd4:    r = {3'b0, a, 1'b0};
      4'd5:    r = {5'b0, a[3:1]};
      4'd6:    r = {4'b0, a[2:0], a[3]};
      4'd7:    r = {4'b0, a[0], a[3:1]};
      4'd8:    r = {4'b0, a & b};
      4'd9:    r = {4'b0, a | b};
      4'd10:   r = {4'b0, a ^ b};
      4'd11:   r = {4'b0, ~(a | b)};
      4'd12:   r = {4'b0, ~(a & b)};
      4'd13:   r = {4'b0, ~(a ^ b)};
      4'd14:   r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {s[4], r};
  endfunction

  // One-cycle-latency ALU stand-in.
  always @(posedge clk) begin
    {alu_carry, alu_out} <= alu_fn(alu_a, alu_b, alu_sel);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: record accepted commands, score every presented result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{a: cmd_a, b: cmd_b, sel: cmd_sel});
        n_push++;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 32'(res_valid), 0);
        end else begin
          logic [8:0] ref_v;
          ref_v = alu_fn(exp_q[0].a, exp_q[0].b, exp_q[0].sel);
          check("res_data",  32'(res_data),  32'(ref_v[7:0]));
          check("res_carry", 32'(res_carry), 32'(ref_v[8]));
          check("res_sel",   32'(res_sel),   32'(exp_q[0].sel));
          if (res_ready) begin
            void'(exp_q.pop_front());
            n_res++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    int k = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("push_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_queue", 32'(exp_q.size()), 0);
    check("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int p0;
    int acc;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_alu_a",     32'(alu_a),     0);
    check("rst_alu_b",     32'(alu_b),     0);
    check("rst_alu_sel",   32'(alu_sel),   0);
    check("rst_res_data",  32'(res_data),  0);
    check("rst_res_carry", 32'(res_carry), 0);
    check("rst_res_sel",   32'(res_sel),   0);

    // Reset mid-WAIT discards the in-flight command
    res_ready = 1'b1;
    cmd_a = 4'h5; cmd_b = 4'h3; cmd_sel = 4'h2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("midwait_busy", 32'(busy), 1);
    check("midwait_alu_a", 32'(alu_a), 32'h5);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_res_valid", 32'(res_valid), 0);
    check("arst_busy",      32'(busy),      0);
    check("arst_cmd_ready", 32'(cmd_ready), 1);
    check("arst_alu_a",     32'(alu_a),     0);
    check("arst_alu_b",     32'(alu_b),     0);
    check("arst_alu_sel",   32'(alu_sel),   0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_res_valid", 32'(res_valid), 0);
    check("post_rst_busy",      32'(busy),      0);

    // Single op latency: alu_* at E+1, res_valid at E+3
    cmd_a = 4'hA; cmd_b = 4'h2; cmd_sel = 4'h0; cmd_valid = 1'b1;
    check("single_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("single_alu_a_e0", 32'(alu_a), 0);
    tick();
    check("single_alu_a_e1",   32'(alu_a),     32'hA);
    check("single_alu_b_e1",   32'(alu_b),     32'h2);
    check("single_alu_sel_e1", 32'(alu_sel),   32'h0);
    check("single_valid_e1",   32'(res_valid), 0);
    check("single_busy_e1",    32'(busy),      1);
    tick();
    check("single_valid_e2", 32'(res_valid), 0);
    tick();
    check("single_valid_e3", 32'(res_valid), 1);
    check("single_data",     32'(res_data),  32'h0C);
    check("single_carry",    32'(res_carry), 0);
    check("single_sel",      32'(res_sel),   0);
    tick();
    check("single_valid_e4", 32'(res_valid), 0);
    check("single_hold_data", 32'(res_data), 32'h0C);
    check("single_busy_e4",  32'(busy),      0);

    // Opcode sweep
    n0 = n_res;
    for (int s = 1; s < 16; s++) push(4'hA, 4'h2, 4'(s));
    wait_idle(200);
    check("sweep_count", 32'(n_res - n0), 15);

    // Backpressure: results held, FIFO fills
    res_ready = 1'b0;
    n0  = n_res;
    acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 4'($urandom);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 5);
    for (int i = 0; i < 4; i++) begin
      check("bp_ready_low", 32'(cmd_ready), 0);
      check("bp_res_valid", 32'(res_valid), 1);
      tick();
    end
    check("bp_no_drain", 32'(n_res - n0), 0);

    // Full FIFO with a pop: no same-cycle bypass
    cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 4'($urandom);
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("fp_res_taken",  32'(res_valid), 0);
    check("fp_ready_full", 32'(cmd_ready), 0);
    tick();
    check("fp_ready_next", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("fp_one_drained", 32'(n_res - n0), 1);
    res_ready = 1'b1;
    wait_idle(200);
    check("bp_drain_count", 32'(n_res - n0), 6);

    // Pointer wrap: 10 commands through the depth-4 FIFO
    n0 = n_res;
    for (int i = 0; i < 10; i++) push(4'($urandom), 4'($urandom), 4'($urandom));
    wait_idle(200);
    check("wrap_count", 32'(n_res - n0), 10);

    // Random traffic with random backpressure
    n0 = n_res;
    p0 = n_push;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_sel   = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(400);
    check("rand_count", 32'(n_res - n0), 32'(n_push - p0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
